// File: rtl/serv_alu.sv
// Bit-serial ALU: add/sub, boolean ops and compare, processed W bits per
// cycle over a 32-bit operand. Carry and compare state chain across chunks.
module serv_alu #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_cnt0,
  input  logic         i_sub,
  input  logic [1:0]   i_bool_op,
  input  logic         i_cmp_eq,
  input  logic         i_cmp_sig,
  input  logic [2:0]   i_rd_sel,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_op_b,
  input  logic [W-1:0] i_buf,
  output logic         o_cmp,
  output logic [W-1:0] o_rd
);

  localparam int unsigned B = W - 1;

  logic         carry_q;
  logic         cmp_q;
  logic [W-1:0] b_inv;
  logic         carry_in;
  logic [W:0]   add_sum;
  logic [W-1:0] result_add;
  logic         cout;
  logic         result_lt;
  logic         result_eq;
  logic [W-1:0] result_bool;
  logic [W-1:0] result_slt;

  // Reserved buffer chunk has no effect on any output.
  logic unused_buf;
  assign unused_buf = ^i_buf;

  // Adder, compare and boolean datapath; a new operation (i_cnt0) ignores
  // whatever state the previous one left behind.
  always_comb begin
    b_inv      = i_op_b ^ {W{i_sub}};
    carry_in   = i_cnt0 ? i_sub : carry_q;
    add_sum    = {1'b0, i_rs1} + {1'b0, b_inv} + {{W{1'b0}}, carry_in};
    result_add = add_sum[W-1:0];
    cout       = add_sum[W];

    // Sign bits folded in so one subtract serves both signed and unsigned.
    result_lt = (i_rs1[B] & i_cmp_sig) ^ ~(i_op_b[B] & i_cmp_sig) ^ cout;
    result_eq = ~|result_add & (cmp_q | i_cnt0);
    o_cmp     = i_cmp_eq ? result_eq : result_lt;

    result_bool = ((i_rs1 ^ i_op_b) & ~{W{i_bool_op[0]}})
                | ({W{i_bool_op[1]}} & i_rs1 & i_op_b);

    // SLT emits the compare result in the LSB chunk only.
    result_slt    = '0;
    result_slt[0] = cmp_q & i_cnt0;
  end

  // Result mux: AND-OR of one-hot selects, all-zero select gives zero.
  always_comb begin
    o_rd = ({W{i_rd_sel[0]}} & result_add)
         | ({W{i_rd_sel[1]}} & result_slt)
         | ({W{i_rd_sel[2]}} & result_bool);
  end

  // Carry clears whenever idle; compare result holds until next enabled cycle.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      carry_q <= 1'b0;
      cmp_q   <= 1'b0;
    end else begin
      carry_q <= i_en & cout;
      if (i_en) begin
        cmp_q <= o_cmp;
      end
    end
  end

endmodule

// File: tb/tb_serv_alu.sv
// Directed testbench for serv_alu with W=1: single-chunk cases and full
// 32-cycle serial operations, checked with immediate assertions.
module tb_serv_alu;

  logic       clk;
  logic       i_rst;
  logic       i_en;
  logic       i_cnt0;
  logic       i_sub;
  logic [1:0] i_bool_op;
  logic       i_cmp_eq;
  logic       i_cmp_sig;
  logic [2:0] i_rd_sel;
  logic [0:0] i_rs1;
  logic [0:0] i_op_b;
  logic [0:0] i_buf;
  logic       o_cmp;
  logic [0:0] o_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] res;
  logic        last_cmp;

  serv_alu #(.W(1)) dut (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_cnt0   (i_cnt0),
    .i_sub    (i_sub),
    .i_bool_op(i_bool_op),
    .i_cmp_eq (i_cmp_eq),
    .i_cmp_sig(i_cmp_sig),
    .i_rd_sel (i_rd_sel),
    .i_rs1    (i_rs1),
    .i_op_b   (i_op_b),
    .i_buf    (i_buf),
    .o_cmp    (o_cmp),
    .o_rd     (o_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one 32-cycle serial operation LSB first with i_en=1, collecting the
  // o_rd bits and the o_cmp value of the final chunk.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic c);
    r = '0;
    c = 1'b0;
    i_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      i_cnt0 = (i == 0);
      i_rs1  = a[i];
      i_op_b = b[i];
      #1;
      r[i] = o_rd[0];
      if (i == 31) c = o_cmp;
      tick();
    end
    i_en = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_cnt0 = 1'b0; i_sub = 1'b0; i_bool_op = 2'b00;
    i_cmp_eq = 1'b0; i_cmp_sig = 1'b0; i_rd_sel = 3'b001;
    i_rs1 = 1'b0; i_op_b = 1'b0; i_buf = 1'b1;
    #1;
    // Reset state: carry 0 so zero operands add to 0; lt = ~cout = 1.
    check("reset_rd_carry", {31'b0, o_rd}, 32'd0);
    check("reset_cmp_lt", {31'b0, o_cmp}, 32'd1);
    i_rd_sel = 3'b010; i_cnt0 = 1'b1;
    #1;
    check("reset_slt", {31'b0, o_rd}, 32'd0);
    #1;
    i_rst = 1'b0;
    tick();

    // Generate a carry: 1+1 gives 0 with carry out.
    i_rd_sel = 3'b001; i_en = 1'b1; i_cnt0 = 1'b1; i_rs1 = 1'b1; i_op_b = 1'b1;
    #1;
    check("add_1p1", {31'b0, o_rd}, 32'd0);
    tick();
    i_cnt0 = 1'b0; i_rs1 = 1'b0; i_op_b = 1'b0;
    #1;
    check("carry_set", {31'b0, o_rd}, 32'd1);

    // ADD case: cnt0 overrides held carry; carry afterwards is 0.
    i_cnt0 = 1'b1; i_rs1 = 1'b1; i_op_b = 1'b0;
    #1;
    check("add_case", {31'b0, o_rd}, 32'd1);
    tick();
    i_cnt0 = 1'b0; i_rs1 = 1'b0;
    #1;
    check("add_carry_after", {31'b0, o_rd}, 32'd0);

    // Carry clears on a cycle with i_en=0.
    i_cnt0 = 1'b1; i_rs1 = 1'b1; i_op_b = 1'b1;
    tick();
    i_en = 1'b0;
    tick();
    i_cnt0 = 1'b0; i_rs1 = 1'b0; i_op_b = 1'b0;
    #1;
    check("carry_clr_en0", {31'b0, o_rd}, 32'd0);

    // SUB case.
    i_sub = 1'b1; i_cnt0 = 1'b1; i_rs1 = 1'b1; i_op_b = 1'b1;
    #1;
    check("sub_rd", {31'b0, o_rd}, 32'd0);
    check("sub_cmp", {31'b0, o_cmp}, 32'd0);

    // BOOL cases.
    i_rd_sel = 3'b100; i_sub = 1'b0; i_rs1 = 1'b1; i_op_b = 1'b0;
    i_bool_op = 2'b00; #1; check("bool_xor", {31'b0, o_rd}, 32'd1);
    i_bool_op = 2'b01; #1; check("bool_zero", {31'b0, o_rd}, 32'd0);
    i_bool_op = 2'b10; #1; check("bool_or", {31'b0, o_rd}, 32'd1);
    i_bool_op = 2'b11; #1; check("bool_and_10", {31'b0, o_rd}, 32'd0);
    i_op_b = 1'b1;     #1; check("bool_and_11", {31'b0, o_rd}, 32'd1);
    i_bool_op = 2'b00; #1; check("bool_xor_11", {31'b0, o_rd}, 32'd0);
    i_rd_sel = 3'b000; #1; check("rd_sel_none", {31'b0, o_rd}, 32'd0);
    tick();

    // Serial 32-bit add and subtract.
    i_rd_sel = 3'b001; i_sub = 1'b0;
    run_op(32'h89AB_CDEF, 32'h1234_5678, res, last_cmp);
    check("serial_add", res, 32'h9BE0_2467);
    i_sub = 1'b1;
    run_op(32'd100, 32'd58, res, last_cmp);
    check("serial_sub", res, 32'd42);
    run_op(32'd5, 32'd7, res, last_cmp);
    check("serial_sub_neg", res, 32'hFFFF_FFFE);

    // Less-than compares.
    i_cmp_eq = 1'b0; i_cmp_sig = 1'b0;
    run_op(32'd5, 32'd7, res, last_cmp);
    check("ltu_5_7", {31'b0, last_cmp}, 32'd1);
    run_op(32'd7, 32'd5, res, last_cmp);
    check("ltu_7_5", {31'b0, last_cmp}, 32'd0);
    run_op(32'd9, 32'd9, res, last_cmp);
    check("ltu_9_9", {31'b0, last_cmp}, 32'd0);
    i_cmp_sig = 1'b1;
    run_op(32'hFFFF_FFFF, 32'd1, res, last_cmp);
    check("lts_m1_1", {31'b0, last_cmp}, 32'd1);
    run_op(32'd1, 32'hFFFF_FFFF, res, last_cmp);
    check("lts_1_m1", {31'b0, last_cmp}, 32'd0);
    i_cmp_sig = 1'b0;
    run_op(32'hFFFF_FFFF, 32'd1, res, last_cmp);
    check("ltu_m1_1", {31'b0, last_cmp}, 32'd0);

    // Equality accumulates over all chunks.
    i_cmp_eq = 1'b1;
    run_op(32'h0000_1235, 32'h0000_1234, res, last_cmp);
    check("eq_diff_lsb", {31'b0, last_cmp}, 32'd0);
    run_op(32'h8000_1234, 32'h0000_1234, res, last_cmp);
    check("eq_diff_msb", {31'b0, last_cmp}, 32'd0);
    run_op(32'h0000_1234, 32'h0000_1234, res, last_cmp);
    check("eq_same", {31'b0, last_cmp}, 32'd1);

    // SLT readout: cmp_r held while i_en=0, emitted only on the cnt0 chunk.
    i_rd_sel = 3'b010; i_cnt0 = 1'b1;
    #1;
    check("slt_cnt0", {31'b0, o_rd}, 32'd1);
    tick();
    #1;
    check("slt_held", {31'b0, o_rd}, 32'd1);
    i_cnt0 = 1'b0;
    #1;
    check("slt_not_cnt0", {31'b0, o_rd}, 32'd0);

    // Reset mid-operation: equal subtract keeps carry=1 and cmp_r=1 going.
    i_rd_sel = 3'b001; i_en = 1'b1; i_sub = 1'b1; i_cmp_eq = 1'b1;
    i_rs1 = 1'b1; i_op_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_cnt0 = (i == 0);
      tick();
    end
    i_en = 1'b0; i_sub = 1'b0; i_cnt0 = 1'b0; i_rs1 = 1'b0; i_op_b = 1'b0;
    #1;
    check("pre_rst_carry", {31'b0, o_rd}, 32'd1);
    i_rd_sel = 3'b010; i_cnt0 = 1'b1;
    #1;
    check("pre_rst_cmp", {31'b0, o_rd}, 32'd1);
    i_rst = 1'b1;
    #1;
    check("rst_cmp_now", {31'b0, o_rd}, 32'd0);
    i_rd_sel = 3'b001; i_cnt0 = 1'b0;
    #1;
    check("rst_carry_now", {31'b0, o_rd}, 32'd0);
    i_rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serv_alu.md
SERV_ALU -- requirements
Module: serv_alu

Interface
REQ-001 SHALL have parameter W, default 1, giving the serial datapath width in bits per cycle; B = W-1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port i_en, input, 1 bit: enables state updates (carry and compare registers).
REQ-005 SHALL have port i_cnt0, input, 1 bit: marks the first (LSB) chunk of a 32-bit serial operation.
REQ-006 SHALL have port i_sub, input, 1 bit: 1 = subtract (invert op_b, carry-in 1); 0 = add.
REQ-007 SHALL have port i_bool_op, input, 2 bits: 00 XOR, 01 zero, 10 OR, 11 AND.
REQ-008 SHALL have port i_cmp_eq, input, 1 bit: o_cmp selects equality (1) or less-than (0).
REQ-009 SHALL have port i_cmp_sig, input, 1 bit: less-than is signed (1) or unsigned (0).
REQ-010 SHALL have port i_rd_sel, input, 3 bits, one-hot: [0] add result, [1] set-less-than result, [2] boolean result.
REQ-011 SHALL have ports i_rs1, i_op_b and i_buf, inputs, W bits each: operand A chunk, operand B chunk, and a reserved buffer chunk that affects no output.
REQ-012 SHALL have port o_cmp, output, 1 bit: combinational compare result.
REQ-013 SHALL have port o_rd, output, W bits: combinational result chunk.

Function
REQ-014 SHALL form b_inv = i_op_b XOR {W{i_sub}}.
REQ-015 SHALL form the carry-in as i_sub when i_cnt0=1, and as the carry register otherwise.
REQ-016 SHALL compute {cout, result_add} = i_rs1 + b_inv + carry-in as a (W+1)-bit sum, with no overflow flag.
REQ-017 SHALL load the carry register with cout at each clock edge where i_en=1, and clear it to 0 at each edge where i_en=0.
REQ-018 SHALL compute result_lt = (i_rs1[B] & i_cmp_sig) XOR NOT(i_op_b[B] & i_cmp_sig) XOR cout; it is valid on the MSB chunk with i_sub=1.
REQ-019 SHALL compute result_eq = (result_add == 0) AND (cmp_r OR i_cnt0); this accumulates over all chunks.
REQ-020 SHALL drive o_cmp = i_cmp_eq ? result_eq : result_lt, combinationally.
REQ-021 SHALL load cmp_r with o_cmp at each edge where i_en=1, and hold cmp_r when i_en=0.
REQ-022 SHALL compute result_bool = ((i_rs1 XOR i_op_b) & ~{W{i_bool_op[0]}}) | ({W{i_bool_op[1]}} & i_rs1 & i_op_b).
REQ-023 SHALL compute result_slt as a W-bit value: bit0 = cmp_r & i_cnt0, all other bits 0.
REQ-024 SHALL drive o_rd as the OR of the results selected by each i_rd_sel bit (AND-gated); i_rd_sel=000 gives 0.
REQ-025 SHALL make the add, bool, compare and output paths zero-latency combinational; the only state is the carry register and cmp_r.
REQ-026 SHALL give i_cnt0 priority over the carry register and cmp_r in the same cycle, so a new operation may start immediately after the previous one.
REQ-027 SHALL leave the carry register and cmp_r unchanged on all cycles where i_en=0, except for the carry clear required by REQ-017.

Reset
REQ-028 SHALL asynchronously clear the carry register and cmp_r to 0 while i_rst=1; outputs then follow the combinational equations with these zeroed states.
REQ-029 SHALL abort any operation in progress when reset is asserted mid-operation; a fresh operation requires i_cnt0=1.

Verification
REQ-030 SHALL pass this ADD case: W=1, rd_sel=001, sub=0, cnt0=1, rs1=1, op_b=0 -> o_rd=1; the carry register then holds 0.
REQ-031 SHALL pass this SUB case: sub=1, cnt0=1, rs1=1, op_b=1, cmp_eq=0, cmp_sig=0 -> o_rd=0, o_cmp=0.
REQ-032 SHALL pass these BOOL cases: rd_sel=100, rs1=1, op_b=0 -> o_rd=1 for op 00 (XOR), 1 for op 10 (OR), 0 for op 11 (AND); with rs1=op_b=1 and op 11 -> o_rd=1.
REQ-033 SHALL pass this serial compare case: 32 cycles with i_en=1, sub=1, cnt0 on cycle 0, rs1=5, op_b=7 -> last-cycle o_cmp=1 (unsigned lt); for rs1=-1, op_b=1 with cmp_sig=1 -> 1, with cmp_sig=0 -> 0.
REQ-034 SHALL pass this EQ/SLT case: 32 cycles, cmp_eq=1, rs1=op_b=0x1234 -> final o_cmp=1 (0 if any bit differs); then i_en=0, rd_sel=010, cnt0=1 -> o_rd=cmp_r, and cnt0=0 -> o_rd=0.
REQ-035 SHALL pass this reset case: i_rst pulsed mid-operation -> carry register and cmp_r read 0 immediately (not waiting for a clock edge).
